// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential radix-4 Booth multiplier, signed/unsigned per transaction,
// valid/ready on both sides, result held under back-pressure.
module seq_booth_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int K  = WIDTH / 2 + 1;
    localparam int CW = $clog2(K + 1);
    localparam int AW = 2 * WIDTH + 4;

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_width_check
        $error("seq_booth_multiplier: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   mcand, acc, addend, acc_next;
    logic [WIDTH+2:0] mplier;
    logic            accept, last;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last      = (cnt == CW'(K - 1));
    assign acc_next  = acc + addend;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? CALC : IDLE;
            CALC:    next_state = last ? DONE : CALC;
            DONE:    next_state = accept ? CALC : (out_ready ? IDLE : DONE);
            default: next_state = IDLE;
        endcase
    end

    // mcand is pre-shifted by 2 bits per digit, so each digit adds in place
    always_comb begin
        addend = '0;
        case (mplier[2:0])
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand << 1;
            3'b100:         addend = -(mcand << 1);
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                mcand  <= {{(AW - WIDTH){signed_mode & a[WIDTH-1]}}, a};
                mplier <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc_next;
                mcand  <= mcand << 2;
                mplier <= {2'b00, mplier[WIDTH+2:2]};
                cnt    <= cnt + 1'b1;
                if (last)
                    product <= acc_next[2*WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed checks on a WIDTH=16 instance plus an exhaustive
// sweep of a WIDTH=4 instance.
module tb_seq_booth_multiplier;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, signed_mode = 0, out_valid, out_ready = 0, busy;
    logic [15:0] a = 0, b = 0;
    logic [31:0] product;
    logic        v4 = 0, r4, m4 = 0, ov4, or4 = 0, busy4;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  p4;
    int total = 0, bad = 0;

    logic [15:0] ca [4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h8000};
    logic [15:0] cb [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002};
    logic        cm [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ce [4] = '{32'h40000000, 32'hC0008000, 32'hFFFE0001, 32'h00010000};

    seq_booth_multiplier #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    seq_booth_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
        .signed_mode(m4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic start(input logic [15:0] x, input logic [15:0] y, input logic m);
        a = x; b = y; signed_mode = m; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h want=0", product); end
    endtask

    task automatic test_signed_basic();
        int n;
        start(16'hFFFD, 16'd5, 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL calc_in_ready got=%b want=0", in_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL calc_busy got=%b want=1", busy); end
        wait_valid(n);
        total++; if (n != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", n); end
        total++; if (product !== 32'hFFFFFFF1) begin bad++; $display("FAIL basic_product got=%h want=fffffff1", product); end
        release_result();
    endtask

    task automatic test_corners();
        int n;
        for (int i = 0; i < 4; i++) begin
            start(ca[i], cb[i], cm[i]);
            wait_valid(n);
            total++; if (n != 9) begin bad++; $display("FAIL corner%0d_latency got=%0d want=9", i, n); end
            total++; if (product !== ce[i]) begin bad++; $display("FAIL corner%0d_product got=%h want=%h", i, product, ce[i]); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int n;
        start(16'd1234, 16'd5678, 1'b0);
        wait_valid(n);
        total++; if (product !== 32'h006AE9BC) begin bad++; $display("FAIL bp_product got=%h want=006ae9bc", product); end
        for (int i = 0; i < 5; i++) begin
            a = ~a; b = ~b;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
            total++; if (product !== 32'h006AE9BC) begin bad++; $display("FAIL bp_hold_product got=%h want=006ae9bc", product); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready got=%b want=0", in_ready); end
        end
        out_ready = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_comb got=%b want=1", in_ready); end
        @(posedge clk); #1;
        out_ready = 0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_to_idle got valid=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic gap;
        start(16'd3, 16'd4, 1'b1);
        wait_valid(n);
        total++; if (product !== 32'd12) begin bad++; $display("FAIL b2b_first got=%h want=0000000c", product); end
        a = 16'd7; b = 16'hFFFE; signed_mode = 1; in_valid = 1; out_ready = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_recalc got valid=%b busy=%b want 0/1", out_valid, busy); end
        n = 0; gap = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) gap = 1;
            @(posedge clk); #1;
            n++;
        end
        total++; if (n != 9 || gap !== 1'b0) begin bad++; $display("FAIL b2b_latency got=%0d gap=%b want 9/0", n, gap); end
        total++; if (product !== 32'hFFFFFFF2) begin bad++; $display("FAIL b2b_product got=%h want=fffffff2", product); end
        release_result();
    endtask

    task automatic test_reset_mid();
        int n;
        start(16'd1000, 16'd1000, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL mid_product got=%h want=0", product); end
        #3 reset = 0;
        @(posedge clk); #1;
        start(16'd100, 16'd200, 1'b0);
        wait_valid(n);
        total++; if (n != 9) begin bad++; $display("FAIL mid_after_latency got=%0d want=9", n); end
        total++; if (product !== 32'h00004E20) begin bad++; $display("FAIL mid_after_product got=%h want=00004e20", product); end
        release_result();
    endtask

    task automatic test_random();
        int n;
        logic [15:0] x, y;
        logic m;
        longint sx, sy;
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            x = 16'($urandom); y = 16'($urandom); m = 1'($urandom_range(0, 1));
            sx = (m && x[15]) ? longint'(x) - 65536 : longint'(x);
            sy = (m && y[15]) ? longint'(y) - 65536 : longint'(y);
            exp = 32'(sx * sy);
            start(x, y, m);
            wait_valid(n);
            total++; if (n != 9) begin bad++; $display("FAIL rand_latency %h*%h m=%b got=%0d want=9", x, y, m, n); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            total++; if (out_valid !== 1'b1 || product !== exp) begin bad++; $display("FAIL rand_product %h*%h m=%b got=%h want=%h", x, y, m, product, exp); end
            release_result();
        end
    endtask

    task automatic test_width4();
        int n, sx, sy;
        logic [7:0] exp;
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    sx = (m == 1 && x >= 8) ? x - 16 : x;
                    sy = (m == 1 && y >= 8) ? y - 16 : y;
                    exp = 8'(sx * sy);
                    a4 = 4'(x); b4 = 4'(y); m4 = 1'(m); v4 = 1;
                    @(posedge clk); #1;
                    v4 = 0; n = 0;
                    while (ov4 !== 1'b1 && n < 50) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    total++; if (n != 3 || p4 !== exp) begin bad++; $display("FAIL w4 %0d*%0d m=%0d got=%h lat=%0d want=%h lat=3", x, y, m, p4, n, exp); end
                    or4 = 1;
                    @(posedge clk); #1;
                    or4 = 0;
                end
    endtask

    initial begin
        #2;
        test_reset();
        #10 reset = 0;
        @(posedge clk); #1;
        test_signed_basic();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Sequential radix-4 Booth multiplier, parametrised in operand width. It supports signed and unsigned operands per transaction and uses valid/ready handshakes on both input and output. It retires two multiplier bits per clock, so latency is about half that of the team's bit-serial shift-and-add multiplier. It also holds the result under output back-pressure. It sits between a producer (e.g. a sample pipeline or a CPU register interface) and a consumer that may stall.

Parameters:
WIDTH, 16, operand width in bits. Must be even and >= 4; elaboration error otherwise.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, signed_mode present
in_ready  output  1  block can accept an operand set this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product this cycle
product  output  2*WIDTH  exact product: signed or unsigned according to signed_mode latched at accept
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async, active-high) forces state IDLE, counter 0, accumulator 0. Outputs under reset: in_ready=1, out_valid=0, product=0, busy=0. Reset has immediate effect and aborts any calculation in flight; no partial result is ever presented.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- Accept edge: latch a, b, signed_mode; clear accumulator and counter; go to CALC.
- Operand inputs are ignored when no accept occurs.
- Operand extension: a and b are extended to WIDTH+2 bits. Extension is sign extension if signed_mode=1, zero extension if signed_mode=0.
- Booth digits are taken from the extended b.
- Iterations: K = WIDTH/2 + 1, one Booth digit per CALC cycle, LSB digit first.
- Digit i uses triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
- Triplet to digit mapping:
  - 000 and 111 -> 0
  - 001 and 010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101 and 110 -> -A
- Internal accumulator is 2*WIDTH+4 bits wide, with arithmetic shift by 2 per iteration (or an equivalent shifted-add formulation).
- After K iterations, product = low 2*WIDTH bits of the exact result. This is exact in both modes, including signed min*min.
- Latency: out_valid rises on the edge exactly K clocks after the accept edge (9 clocks for WIDTH=16). State goes CALC -> DONE on that edge.
- DONE state:
  - product is held stable and out_valid stays 1 until out_valid && out_ready.
  - Handshake edge without a new accept: go to IDLE, out_valid=0. product keeps its last value (don't-care for the consumer).
  - Handshake and accept on the same edge (back-to-back): go directly to CALC with the new operands, out_valid=0.
  - Sustained throughput is 1 result per K+1 cycles.
- out_ready is ignored while out_valid=0.
- in_valid is ignored while in_ready=0; the producer must hold its data.
- busy = (state != IDLE).
- Counter width: clog2(K+1). The counter never wraps in normal operation.
- No combinational path from in_valid, a, b to any output. in_ready depends combinationally on out_ready only.

Test Plan:
- Signed, WIDTH=16: a=-3 (0xFFFD), b=5, signed_mode=1 -> after 9 clocks out_valid=1, product=0xFFFFFFF1. Check in_ready=0 and busy=1 during CALC.
- Corner operands:
  - signed -32768*-32768 -> 0x40000000
  - signed -32768*32767 -> 0xC0008000
  - unsigned 0xFFFF*0xFFFF -> 0xFFFE0001
  - unsigned 0x8000*2 -> 0x00010000
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid. product stays constant, out_valid stays 1, in_ready stays 0, a and b toggled with no effect. Then out_ready=1 -> IDLE next edge.
- Back-to-back: with out_ready=1 and in_valid=1 in the DONE cycle, new operands 7*-2 (signed) are accepted on the same edge. Next result 0xFFFFFFF2 arrives exactly 9 clocks later, with no IDLE cycle in between.
- Reset mid-operation: assert reset asynchronously (between edges) 3 cycles into CALC. Outputs immediately show out_valid=0, in_ready=1, busy=0, product=0. A subsequent transaction 100*200 -> 20000 (0x00004E20) is correct.
- Random regression: at least 10k random a, b, and mode values with random out_ready stalls, at WIDTH=4, 8, 16, 32. Every product matches the reference model and latency is always K.
